fifo_uart_tx: RTL



---
 rtl/fifo_uart_tx.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drain stage on the read side of an asynchronous FIFO.
// Pops one word at a time through the FIFO's first-word-fall-through read port.
// Each word is sent as DATA_WIDTH/8 UART 8N1 frames, least significant byte first.
//
// Ports:
//   clk        read-domain clock; all logic runs on posedge
//   rst        synchronous, active-high reset
//   en         allows a new word to start (a word in flight always completes)
//   rempty     FIFO empty flag
//   rdata      FIFO head word, valid while rempty = 0
//   rpull      FIFO pop strobe; one registered pulse in the first start-bit cycle
//   tx         UART serial output, idle high
//   busy       high while a word is being transmitted
//   words_sent count of fully transmitted words; wraps to 0
module fifo_uart_tx #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  rempty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rpull,
    output logic                  tx,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  words_sent
);

    localparam int unsigned NumBytes = DATA_WIDTH / 8;
    localparam int unsigned BaudW    = $clog2(CLKS_PER_BIT);
    localparam int unsigned ByteW    = (NumBytes > 1) ? $clog2(NumBytes) : 1;

    localparam logic [BaudW-1:0] BaudMax = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [ByteW-1:0] ByteMax = ByteW'(NumBytes - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [BaudW-1:0]      baud_q, baud_d;
    logic [2:0]            bit_q, bit_d;
    logic [ByteW-1:0]      byte_q, byte_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  tx_q, tx_d;
    logic                  rpull_q, rpull_d;

    logic [7:0] cur_byte;
    logic       baud_done;

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        cnt_d     = cnt_q;
        tx_d      = tx_q;
        rpull_d   = 1'b0;
        cur_byte  = 8'(word_q >> {byte_q, 3'b000});
        baud_done = (baud_q == BaudMax);

        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (en && !rempty) begin
                    // Latch the head word now; the pop lands during the first start-bit cycle.
                    word_d  = rdata;
                    rpull_d = 1'b1;
                    state_d = StStart;
                    byte_d  = '0;
                    baud_d  = '0;
                    tx_d    = 1'b0;
                end
            end
            StStart: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StData;
                    tx_d    = cur_byte[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = cur_byte[bit_d];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StStop: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (byte_q == ByteMax) begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = StIdle;
                        tx_d    = 1'b1;
                    end else begin
                        byte_d  = byte_q + 1'b1;
                        state_d = StStart;
                        tx_d    = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            word_q  <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            rpull_q <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            rpull_q <= rpull_d;
        end
    end

    assign rpull      = rpull_q;
    assign tx         = tx_q;
    assign busy       = (state_q != StIdle);
    assign words_sent = cnt_q;

endmodule
